// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// General-purpose holding/shifting register. In IDLE it behaves as a
// parallel-load register with per-cycle shift/rotate modes. A start request
// runs a multi-cycle "shift by amt" operation with a busy/done handshake.
//
// Parameters
//   WIDTH  register width in bits (>= 2)
//   AMT_W  width of the shift-amount input
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   ld      parallel load enable (IDLE only)
//   din     parallel load data
//   mode    shift mode: 000 HOLD, 001 SHL, 010 SHR, 011 ROL, 100 ROR,
//           101 ASR, 110/111 HOLD
//   start   request a multi-cycle shift of amt steps (IDLE only)
//   amt     step count for start
//   sin_r   serial bit entering the LSB on SHL
//   sin_l   serial bit entering the MSB on SHR
//   dout    register contents
//   sout_l  dout[WIDTH-1]
//   sout_r  dout[0]
//   busy    multi-cycle shift in progress
//   done    one-cycle pulse after the last step of a multi-cycle shift
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] dout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_ASR  = 3'b101
  } shift_mode_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       lmode_q, lmode_d;
  logic             done_q, done_d;

  // One step of the selected mode; reserved encodings fall through to hold.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] d,
    input logic             sr,
    input logic             sl
  );
    case (shift_mode_e'(m))
      M_SHL:   shift_step = {d[WIDTH-2:0], sr};
      M_SHR:   shift_step = {sl, d[WIDTH-1:1]};
      M_ROL:   shift_step = {d[WIDTH-2:0], d[WIDTH-1]};
      M_ROR:   shift_step = {d[0], d[WIDTH-1:1]};
      M_ASR:   shift_step = {d[WIDTH-1], d[WIDTH-1:1]};
      default: shift_step = d;
    endcase
  endfunction

  // count_q holds the steps still to apply after the current edge; the run
  // ends on the edge where it reads 1, so the counter never wraps.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    lmode_d = lmode_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld) begin
          data_d = din;
        end else if (start) begin
          lmode_d = mode;
          if (amt != '0) data_d = shift_step(mode, data_q, sin_r, sin_l);
          if (amt <= AMT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            count_d = amt - AMT_W'(1);
            state_d = S_RUN;
          end
        end else begin
          data_d = shift_step(mode, data_q, sin_r, sin_l);
        end
      end

      S_RUN: begin
        data_d  = shift_step(lmode_q, data_q, sin_r, sin_l);
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: all control and data state is reset, including the latched mode,
      // so a reset mid-run leaves no stale operation behind.
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      lmode_q <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      lmode_q <= lmode_d;
      done_q  <= done_d;
    end
  end

  assign dout   = data_q;
  assign sout_l = data_q[WIDTH-1];
  assign sout_r = data_q[0];
  assign busy   = (state_q == S_RUN);
  assign done   = done_q;

endmodule
